obf_gate_keyed: RTL and testbench
=================================

Name: obf_gate_keyed

Overview:
- Parametrised, key-programmable camouflaged logic gate: successor to the fixed 4-input obfuscated NAND cell.
- Each of the N_IN inputs and the single output passes through a 2-bit camouflage selector: pass, invert, const1 or const0.
- The key is loaded serially through a handshake into a shadow register and committed atomically; the output is registered with a valid strobe.
- Sits between the key-provisioning controller and the obfuscated datapath in camouflage test netlists.

Parameters:
- N_IN, 4, number of gate inputs; legal range 2..16.
- FUNC, 0, core function: 0 NAND, 1 AND, 2 NOR, 3 OR, 4 XOR, 5 XNOR.
- KEY_W (localparam), 2*(N_IN+1), total key bits.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- din  in  N_IN  gate inputs.
- din_valid  in  1  din qualifier.
- dout  out  1  registered obfuscated gate output.
- dout_valid  out  1  dout qualifier.
- key_bit  in  1  serial key data.
- key_valid  in  1  key_bit qualifier.
- key_ready  out  1  key bit accepted when key_valid && key_ready.
- key_abort  in  1  discard a partial load.
- key_done  out  1  one-cycle pulse when the key commits.
- keyed  out  1  a valid key is active.

Behaviour:
- Code per pin i (outputs use i=N_IN): code[1]=key[2i], code[0]=key[2i+1].
  - 00: pass.
  - 01: invert.
  - 10: const1.
  - 11: const0.
- Datapath:
  - Apply the codes to din.
  - Apply FUNC to the selected inputs.
  - Apply the output code.
  - Register the result.
  - Latency is 1 cycle: din_valid at cycle t gives dout/dout_valid at t+1.
- States:
  - UNKEYED: reset state. din is ignored; dout_valid=0.
  - LOADING: shifting key bits.
  - KEYED: operational.
- Shift order: LSB-first. The first accepted bit ends in key[0] after KEY_W bits. Bit count is held in a counter of width clog2(KEY_W+1).
- UNKEYED -> LOADING on the first accepted bit.
- KEYED -> LOADING on an accepted bit. keyed stays 1 and the datapath keeps using the old active key.
- LOADING, on the KEY_W-th accepted bit:
  - Copy shadow to active in the same edge.
  - Pulse key_done for one cycle.
  - Go to KEYED and set keyed=1.
- din_valid in the commit cycle is evaluated with the OLD key. The new key applies from the next cycle.
- key_abort in LOADING:
  - Clears the shadow register and counter.
  - Returns to KEYED if keyed=1, otherwise to UNKEYED.
  - key_abort has priority over a simultaneous key bit; that bit is dropped.
  - key_abort is ignored in other states.
- key_ready=1 in all states except as restricted by the optional feature.
- In UNKEYED and while LOADING with keyed=0, dout_valid=0.
- dout holds its last value when din_valid=0; dout_valid=0 in that case.
- Reset values:
  - dout=0, dout_valid=0, key_done=0, keyed=0, key_ready=1.
  - Active key, shadow register and counter = 0.
  - State = UNKEYED.
- Reset during LOADING discards everything, including a previously active key.

Optional Feature:
- Macro: OBF_KEY_LOCK_EN.
- When defined:
  - After the first commit, a sticky lock is set.
  - key_ready=0 and key bits are ignored until rst.
  - key_abort has no effect.
- When undefined: reload is allowed indefinitely, as described above.

Decomposition:
- Package obf_pkg holds:
  - Code constants OBF_PASS=2'b00, OBF_INV=2'b01, OBF_C1=2'b10, OBF_C0=2'b11.
  - The FUNC encoding constants.
  - The state typedef.
- One sub-module, obf_pin_sel: a combinational 1-bit selector taking (in, code) and producing out. It is instantiated N_IN+1 times.
- Key FSM, shift register and FUNC reduction stay in the top level.

Test Plan (N_IN=4, FUNC=0, KEY_W=10):
- All-pass key:
  - Load 10'h000; key_done pulses one cycle after the 10th bit.
  - din=4'b1111 -> dout=0 at t+1.
  - din=4'b0111 -> dout=1.
- Input-0 invert, key 10'h002:
  - din=4'b1110 -> dout=0.
  - din=4'b1111 -> dout=1.
- Output const1, key 10'h100: din sweep of all 16 values -> dout=1 every time, dout_valid follows din_valid by one cycle.
- Reload and commit-edge behaviour:
  - From KEYED(10'h000), load 10'h002 while driving din=4'b1110 every cycle.
  - dout=1 until the cycle after commit, then 0.
  - key_abort after 5 bits leaves the old key active and keyed=1.
- Reset and unkeyed handling:
  - rst after 6 bits -> keyed=0, state UNKEYED.
  - din_valid=1 in UNKEYED -> dout_valid stays 0.
- With OBF_KEY_LOCK_EN: after the first commit, key_ready=0; 10 further key_valid pulses -> key unchanged, no key_done.

Source files
------------

// File: rtl/obf_pkg.sv
// Shared definitions for the key-programmable camouflaged gate: pin selector
// codes, core function encodings and the key-load state type.
package obf_pkg;

  localparam logic [1:0] OBF_PASS = 2'b00;
  localparam logic [1:0] OBF_INV  = 2'b01;
  localparam logic [1:0] OBF_C1   = 2'b10;
  localparam logic [1:0] OBF_C0   = 2'b11;

  localparam int FUNC_NAND = 0;
  localparam int FUNC_AND  = 1;
  localparam int FUNC_NOR  = 2;
  localparam int FUNC_OR   = 3;
  localparam int FUNC_XOR  = 4;
  localparam int FUNC_XNOR = 5;

  typedef enum logic [1:0] {
    ST_UNKEYED = 2'd0,
    ST_LOADING = 2'd1,
    ST_KEYED   = 2'd2
  } obf_state_e;

endpackage

// File: rtl/obf_pin_sel.sv
// Combinational camouflage selector for one pin: pass, invert, force 1 or
// force 0 depending on the 2-bit code.
module obf_pin_sel
  import obf_pkg::*;
(
  input  logic       i_in,
  input  logic [1:0] i_code,
  output logic       o_out
);

  always_comb begin
    o_out = i_in;
    case (i_code)
      OBF_PASS: o_out = i_in;
      OBF_INV:  o_out = ~i_in;
      OBF_C1:   o_out = 1'b1;
      default:  o_out = 1'b0;
    endcase
  end

endmodule

// File: rtl/obf_gate_keyed.sv
// Key-programmable camouflaged gate with serial shadow-key load and atomic commit.
// Optional macro OBF_KEY_LOCK_EN makes the key write-once until reset.
module obf_gate_keyed
  import obf_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int FUNC = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] din,
  input  logic            din_valid,
  output logic            dout,
  output logic            dout_valid,
  input  logic            key_bit,
  input  logic            key_valid,
  output logic            key_ready,
  input  logic            key_abort,
  output logic            key_done,
  output logic            keyed
);

  localparam int KEY_W = 2 * (N_IN + 1);
  localparam int CNT_W = $clog2(KEY_W + 1);

  obf_state_e       r_state;
  obf_state_e       w_next_state;
  logic [KEY_W-1:0] r_shadow;
  logic [KEY_W-1:0] r_active;
  logic [KEY_W-1:0] w_shifted;
  logic [CNT_W-1:0] r_cnt;
  logic             r_keyed;
  logic             r_key_done;
  logic             r_dout;
  logic             r_dout_valid;
  logic             w_lock;
  logic             w_accept;
  logic             w_abort;
  logic             w_commit;
  logic [N_IN-1:0]  w_sel;
  logic             w_func;
  logic             w_out;

`ifdef OBF_KEY_LOCK_EN
  logic r_lock;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock <= 1'b0;
    end else if (w_commit) begin
      r_lock <= 1'b1;
    end
  end

  assign w_lock = r_lock;
`else
  assign w_lock = 1'b0;
`endif

  assign key_ready = ~w_lock;
  assign w_accept  = key_valid & ~w_lock;
  // LSB-first: new bits enter at the top so the first bit lands in key[0]
  assign w_shifted = {key_bit, r_shadow[KEY_W-1:1]};

  always_comb begin
    w_next_state = r_state;
    w_abort      = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_UNKEYED, ST_KEYED: begin
        if (w_accept) begin
          w_next_state = ST_LOADING;
        end
      end
      ST_LOADING: begin
        if (key_abort && !w_lock) begin
          w_abort      = 1'b1;
          w_next_state = r_keyed ? ST_KEYED : ST_UNKEYED;
        end else if (w_accept && (r_cnt == CNT_W'(KEY_W - 1))) begin
          w_commit     = 1'b1;
          w_next_state = ST_KEYED;
        end
      end
      default: w_next_state = ST_UNKEYED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_UNKEYED;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow   <= '0;
      r_active   <= '0;
      r_cnt      <= '0;
      r_keyed    <= 1'b0;
      r_key_done <= 1'b0;
    end else begin
      r_key_done <= w_commit;
      if (w_abort) begin
        r_shadow <= '0;
        r_cnt    <= '0;
      end else if (w_commit) begin
        r_active <= w_shifted;
        r_shadow <= '0;
        r_cnt    <= '0;
        r_keyed  <= 1'b1;
      end else if (w_accept) begin
        r_shadow <= w_shifted;
        r_cnt    <= r_cnt + CNT_W'(1);
      end
    end
  end

  for (genvar i = 0; i < N_IN; i++) begin : g_in_sel
    obf_pin_sel u_sel (
      .i_in   (din[i]),
      .i_code ({r_active[2*i], r_active[2*i+1]}),
      .o_out  (w_sel[i])
    );
  end

  always_comb begin
    w_func = ~&w_sel;
    case (FUNC)
      FUNC_AND:  w_func = &w_sel;
      FUNC_NOR:  w_func = ~|w_sel;
      FUNC_OR:   w_func = |w_sel;
      FUNC_XOR:  w_func = ^w_sel;
      FUNC_XNOR: w_func = ~^w_sel;
      default:   w_func = ~&w_sel;
    endcase
  end

  obf_pin_sel u_out_sel (
    .i_in   (w_func),
    .i_code ({r_active[2*N_IN], r_active[2*N_IN+1]}),
    .o_out  (w_out)
  );

  // The active key only changes at commit, so a din in the commit cycle sees the old key
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= din_valid & r_keyed;
      if (din_valid && r_keyed) begin
        r_dout <= w_out;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign key_done   = r_key_done;
  assign keyed      = r_keyed;

endmodule

// File: tb/tb_obf_gate_keyed.sv
// Scoreboard bench for obf_gate_keyed (N_IN=4, NAND): directed key loads plus
// randomized traffic against a behavioural model of keying and gate evaluation.
module tb_obf_gate_keyed;

  localparam int N_IN  = 4;
  localparam int KEY_W = 2 * (N_IN + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic [N_IN-1:0] din;
  logic            din_valid;
  logic            dout;
  logic            dout_valid;
  logic            key_bit;
  logic            key_valid;
  logic            key_ready;
  logic            key_abort;
  logic            key_done;
  logic            keyed;

  int vectors = 0;
  int miscompares = 0;

  bit   expQ[$];
  logic lastDout;

  int               mState;
  logic [KEY_W-1:0] mActive;
  bit               mBits[$];
  bit               mKeyed;
  bit               mLocked;
  bit               mDone;

  always #5 clk = ~clk;

  obf_gate_keyed #(.N_IN(N_IN), .FUNC(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .key_bit    (key_bit),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_abort  (key_abort),
    .key_done   (key_done),
    .keyed      (keyed)
  );

  function automatic bit applyCode(int code, bit v);
    case (code)
      0:       return v;
      1:       return !v;
      2:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // NAND of camouflaged inputs, then the output camouflage
  function automatic bit refGate(logic [KEY_W-1:0] key, logic [N_IN-1:0] d);
    int ones = 0;
    int code;
    bit r;
    for (int i = 0; i < N_IN; i++) begin
      code = 2 * int'(key[2*i]) + int'(key[2*i+1]);
      ones += int'(applyCode(code, d[i]));
    end
    r = (ones != N_IN);
    code = 2 * int'(key[2*N_IN]) + int'(key[2*N_IN+1]);
    return applyCode(code, r);
  endfunction

  task automatic checkOutput(string name, logic actual, logic expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mState  = 0;
    mActive = '0;
    mBits.delete();
    mKeyed  = 1'b0;
    mLocked = 1'b0;
    mDone   = 1'b0;
  endtask

  task automatic resetDut();
    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    key_valid = 1'b0;
    key_bit   = 1'b0;
    key_abort = 1'b0;
    @(posedge clk);
    #1;
    expQ.delete();
    lastDout = 1'b0;
    modelReset();
    rst = 1'b0;
  endtask

  task automatic applyStimulus(bit dv, logic [N_IN-1:0] d, bit kv, bit kb, bit ka);
    bit pendValid;
    bit pendVal;
    din_valid = dv;
    din       = d;
    key_valid = kv;
    key_bit   = kb;
    key_abort = ka;
    pendValid = dv && mKeyed;
    pendVal   = refGate(mActive, d);
    @(posedge clk);
    #1;
    if (pendValid) expQ.push_back(pendVal);
    mDone = 1'b0;
    if (mState == 1 && ka && !mLocked) begin
      mBits.delete();
      mState = mKeyed ? 2 : 0;
    end else if (kv && !mLocked) begin
      mBits.push_back(kb);
      if (mBits.size() == KEY_W) begin
        for (int j = 0; j < KEY_W; j++) mActive[j] = mBits[j];
        mBits.delete();
        mKeyed = 1'b1;
        mDone  = 1'b1;
        mState = 2;
`ifdef OBF_KEY_LOCK_EN
        mLocked = 1'b1;
`endif
      end else begin
        mState = 1;
      end
    end
  endtask

  task automatic loadKey(logic [KEY_W-1:0] key, bit dv, logic [N_IN-1:0] d);
    for (int j = 0; j < KEY_W; j++) applyStimulus(dv, d, 1'b1, key[j], 1'b0);
  endtask

  always @(negedge clk) begin
    bit e;
    checkOutput("dout_valid", dout_valid, expQ.size() > 0);
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      if (dout_valid) checkOutput("dout", dout, e);
      lastDout = e;
    end else begin
      checkOutput("dout_hold", dout, lastDout);
    end
    checkOutput("keyed", keyed, mKeyed);
    checkOutput("key_done", key_done, mDone);
    checkOutput("key_ready", key_ready, !mLocked);
  end

  initial begin
    logic [KEY_W-1:0] k;
    resetDut();

    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);

    loadKey(10'h000, 1'b0, 4'b0000);
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b0111, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0, 1'b0);

    loadKey(10'h002, 1'b0, 4'b0000);
    applyStimulus(1'b1, 4'b1110, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);

    loadKey(10'h100, 1'b0, 4'b0000);
    for (int v = 0; v < 16; v++) begin
      applyStimulus(1'b1, 4'(v), 1'b0, 1'b0, 1'b0);
      if (v % 4 == 3) applyStimulus(1'b0, 4'(v), 1'b0, 1'b0, 1'b0);
    end

    loadKey(10'h000, 1'b0, 4'b0000);
    loadKey(10'h002, 1'b1, 4'b1110);
    for (int j = 0; j < 3; j++) applyStimulus(1'b1, 4'b1110, 1'b0, 1'b0, 1'b0);

    k = 10'h3FF;
    for (int j = 0; j < 5; j++) applyStimulus(1'b1, 4'b1110, 1'b1, k[j], 1'b0);
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b1, 1'b1);
    for (int j = 0; j < 3; j++) applyStimulus(1'b1, 4'(j), 1'b0, 1'b0, 1'b0);

    for (int j = 0; j < 10; j++) applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b1010, 1'b0, 1'b0, 1'b0);

    resetDut();
    for (int j = 0; j < 6; j++) applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
    resetDut();
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b0101, 1'b0, 1'b0, 1'b0);

    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        resetDut();
      end else begin
        applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                      $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 15) == 0);
      end
    end

    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("queue_drained", expQ.size() == 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
